// File: rtl/pot_dot_accumulator.sv
// Signed dot-product accumulator placed after the power-of-two shift
// multiplier. Sums VECTOR_LENGTH signed products into one result and holds
// that result on a registered output until the next stage takes it.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds valid and data steady until that edge. The
// consumer's ready may depend only on its own state, never on the valid it
// receives. Here in_ready and out_valid come straight from the state
// register, so neither in_valid nor out_ready has a combinational path to
// any output.
module pot_dot_accumulator #(
  parameter int WEIGHT_BIT_WIDTH = 4,
  parameter int INPUT_BIT_WIDTH  = 4,
  parameter int VECTOR_LENGTH    = 8,
  localparam int PRODUCT_BIT_WIDTH = INPUT_BIT_WIDTH + (2**WEIGHT_BIT_WIDTH) / 2,
  localparam int ACC_BIT_WIDTH     = PRODUCT_BIT_WIDTH + $clog2(VECTOR_LENGTH),
  localparam int CNT_W             = $clog2(VECTOR_LENGTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PRODUCT_BIT_WIDTH-1:0] in_product,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_BIT_WIDTH-1:0]     out_sum,
  output logic [CNT_W-1:0]             count
);

  // The accept that arrives while count holds this value completes the vector.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VECTOR_LENGTH - 1);

  // ACCUM collects products. HOLD presents the finished sum. The state
  // register is named state_q so checkers can bind to it directly.
  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [ACC_BIT_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_BIT_WIDTH-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0]         count_q, count_d;

  logic [ACC_BIT_WIDTH-1:0] prod_ext;
  logic [ACC_BIT_WIDTH-1:0] acc_sum;
  logic                     accept;

  // Sign-extend the product. The width is sized so that VECTOR_LENGTH
  // full-scale products cannot wrap, so no saturation logic is needed.
  assign prod_ext = {{(ACC_BIT_WIDTH - PRODUCT_BIT_WIDTH){in_product[PRODUCT_BIT_WIDTH-1]}},
                     in_product};
  assign acc_sum  = acc_q + prod_ext;
  assign accept   = in_valid && in_ready;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = out_sum_q;
  assign count     = count_q;

  // Next-state logic: accumulate in ACCUM, release the result in HOLD.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    out_sum_d = out_sum_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d   = acc_sum;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_IDX) begin
            out_sum_d = acc_sum;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        // in_valid is ignored here. Nothing is accepted in the release cycle.
        if (out_ready) begin
          acc_d   = '0;
          count_d = '0;
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // State registers with synchronous reset. Reset discards any partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      count_q   <= '0;
      out_sum_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      out_sum_q <= out_sum_d;
    end
  end

endmodule

// File: tb/tb_pot_dot_accumulator.sv
// Directed bench for pot_dot_accumulator. A queue-based reference model
// tracks the accepted products and the expected result. A single compare
// process checks every DUT output against that model on each falling edge.
// Literal checks on the finished sums pin the model to hand-computed values.
module tb_pot_dot_accumulator;

  localparam int WBW = 4;
  localparam int IBW = 4;
  localparam int VL  = 8;
  localparam int PW  = IBW + (2**WBW) / 2;
  localparam int AW  = PW + $clog2(VL);
  localparam int CW  = $clog2(VL + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_product;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_errors = 0;

  pot_dot_accumulator #(
    .WEIGHT_BIT_WIDTH(WBW),
    .INPUT_BIT_WIDTH (IBW),
    .VECTOR_LENGTH   (VL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_product(in_product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- comparison helper ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Products accepted into the current vector.
  logic [PW-1:0] exp_q[$];
  bit  m_on   = 1'b0;
  bit  m_hold = 1'b0;
  int  m_sum  = 0;

  // Update the model from the inputs the DUT sees at the same edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_hold = 1'b0;
      m_sum  = 0;
      m_on   = 1'b1;
    end else if (m_on) begin
      if (m_hold) begin
        if (out_ready) begin
          m_hold = 1'b0;
          exp_q.delete();
        end
      end else if (in_valid) begin
        exp_q.push_back(in_product);
        if (exp_q.size() == VL) begin
          int s;
          s = 0;
          foreach (exp_q[i]) s += int'($signed(exp_q[i]));
          m_sum  = s;
          m_hold = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (m_on && !rst) begin
      check("in_ready",  int'(in_ready),  int'(!m_hold));
      check("out_valid", int'(out_valid), int'(m_hold));
      check("count",     int'(count),     m_hold ? VL : exp_q.size());
      check("out_sum",   int'($signed(out_sum)), m_sum);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one product and hold it until the DUT accepts it, with a cycle bound.
  task automatic send(input int value);
    int guard;
    in_valid   = 1'b1;
    in_product = PW'(value);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, sampled on falling edges, up to a bounded number of cycles.
  task automatic wait_result(input string name, input int exp_sum, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!out_valid && waited < 50);
    check({name, "_valid"}, int'(out_valid), 1);
    check({name, "_sum"}, int'($signed(out_sum)), exp_sum);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int w;
    int gap;
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_product = PW'(100);
    out_ready  = 1'b1;

    // Reset: two cycles with a valid product presented; nothing may accumulate.
    idle_cycles(2);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_sum",   int'($signed(out_sum)), 0);
    check("rst_count",     int'(count), 0);
    check("rst_in_ready",  int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Basic vector 1..8. The result is valid one cycle after the 8th accept.
    for (int i = 1; i <= VL; i++) send(i);
    wait_result("basic", 36, w);
    check("basic_latency", w, 1);
    @(negedge clk);
    check("basic_ready_again", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Extremes: full-scale negative and positive products must not wrap.
    for (int i = 0; i < VL; i++) send(-1920);
    wait_result("neg_extreme", -15360, w);
    @(posedge clk);
    #1;
    for (int i = 0; i < VL; i++) send(1920);
    wait_result("pos_extreme", 15360, w);
    @(posedge clk);
    #1;

    // Backpressure: the result is held while out_ready is low, even with in_valid high.
    out_ready = 1'b0;
    for (int i = 0; i < VL; i++) send((i % 2 == 0) ? 5 : -3);
    in_valid   = 1'b1;
    in_product = PW'(77);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sum",      int'($signed(out_sum)), 8);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_count",    int'(count), VL);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_count", int'(count), 0);

    // Next vector after the release must start from zero: 8 x 1 = 8.
    for (int i = 0; i < VL; i++) send(1);
    wait_result("after_bp", 8, w);
    @(posedge clk);
    #1;

    // Bubbles: random idle gaps between accepts.
    for (int i = 0; i < VL; i++) begin
      gap = $urandom_range(0, 3);
      idle_cycles(gap);
      send(10);
    end
    wait_result("bubbles", 80, w);
    @(posedge clk);
    #1;

    // Mid-vector reset discards the partial sum.
    for (int i = 0; i < 3; i++) send(100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_count", int'(count), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < VL; i++) send(2);
    wait_result("midrst", 16, w);
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pot_dot_accumulator.md
Name: pot_dot_accumulator

Overview:
- Sequential accumulator directly downstream of the unsigned power-of-two shift multiplier.
- Consumes one signed PoT product per accepted handshake and sums exactly VECTOR_LENGTH products into one signed dot-product result.
- Presents the result on a registered valid/ready output and holds it until the next stage (activation/requantiser) accepts it.

Parameters:
- WEIGHT_BIT_WIDTH, 4, weight code width of the upstream multiplier (1 sign bit + exponent).
- INPUT_BIT_WIDTH, 4, unsigned activation width of the upstream multiplier.
- VECTOR_LENGTH, 8, products per dot product; must be >= 2.
- PRODUCT_BIT_WIDTH (localparam), INPUT_BIT_WIDTH + (2**WEIGHT_BIT_WIDTH)/2 (=12), signed product width; matches upstream output.
- ACC_BIT_WIDTH (localparam), PRODUCT_BIT_WIDTH + $clog2(VECTOR_LENGTH) (=15), signed result width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream product valid.
- in_ready  output  1  block can accept a product this cycle.
- in_product  input  PRODUCT_BIT_WIDTH  signed product from the PoT multiplier.
- out_valid  output  1  out_sum holds a completed dot product.
- out_ready  input  1  downstream accepts out_sum.
- out_sum  output  ACC_BIT_WIDTH  signed dot-product result.
- count  output  $clog2(VECTOR_LENGTH+1)  products accepted into the current vector.

Behaviour:
- One clock; reset is synchronous and active-high.
- On rst:
  - state = ACCUM.
  - acc = 0, count = 0, out_valid = 0, out_sum = 0.
  - in_ready = 1 from the first cycle after reset release.
- rst overrides all other events in the same cycle.
- Accept: in_valid && in_ready at a rising edge.
- States:
  - ACCUM:
    - in_ready = 1, out_valid = 0.
    - On accept: acc <= acc + sign_extend(in_product); count <= count + 1.
    - On the accept that brings count to VECTOR_LENGTH: out_sum <= final sum; go to HOLD.
  - HOLD:
    - in_ready = 0, out_valid = 1.
    - out_sum is stable while out_ready = 0.
    - When out_ready = 1: acc <= 0, count <= 0, go to ACCUM.
    - in_ready rises the cycle after the output handshake.
    - No product is accepted in the handshake cycle; in_valid is ignored throughout HOLD.
- Latency: out_valid asserts the cycle after the VECTOR_LENGTH-th accept.
- Throughput: VECTOR_LENGTH + 1 cycles per vector minimum.
- Bubbles: in_valid = 0 cycles do not change acc or count.
- Arithmetic:
  - Two's complement throughout; each product is sign-extended to ACC_BIT_WIDTH before adding.
  - ACC_BIT_WIDTH is sized so that no overflow occurs for any PRODUCT_BIT_WIDTH inputs. No saturation logic.
- count reads VECTOR_LENGTH during HOLD and 0 after reset or after the output handshake.
- Reset mid-vector or in HOLD: partial sum is discarded; the next vector starts clean.
- in_ready, out_valid and out_sum are driven from registers/state only. There is no combinational path from in_valid or out_ready to them.

Test Plan:
- Reset: assert rst 2 cycles with in_valid = 1, in_product = 100 -> out_valid = 0, out_sum = 0, count = 0, in_ready = 1 after release; nothing accumulated.
- Basic vector: products 1,2,...,8 on consecutive cycles, out_ready = 1 -> out_valid = 1 one cycle after the 8th accept, out_sum = 36; in_ready = 1 again one cycle later.
- Extremes: eight products of -1920 (i.e. -(15<<7)) -> out_sum = -15360. Eight products of +1920 -> out_sum = 15360. No wrap.
- Backpressure: complete a vector of alternating +5/-3 (sum 8), hold out_ready = 0 for 5 cycles while driving in_valid = 1 -> out_sum stays 8, in_ready = 0, count = 8. On out_ready = 1 the next vector starts with acc = 0.
- Bubbles: products 10 on cycles separated by random in_valid = 0 gaps (8 accepts total) -> out_sum = 80; count increments only on accepts.
- Mid-vector reset: accept 3 products of 100, assert rst 1 cycle, then accept eight products of 2 -> out_sum = 16.
